// File: rtl/systolic_input_skewer.sv
// systolic_input_skewer
// Accepts whole activation tiles into a two-entry ping-pong buffer and replays
// each tile as 2N-1 diagonally skewed words for the systolic array. Lane j of
// word k carries a[k-j][j] (zero outside the tile). Back-to-back tiles stream
// without an idle cycle.
module systolic_input_skewer #(
   parameter int N      = 4,
   parameter int DATA_W = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [N*N*DATA_W-1:0] in_tile,
   output logic [N*DATA_W-1:0]   out_datain,
   output logic                  out_valid,
   output logic                  out_first,
   output logic                  out_last,
   output logic                  busy
);

   localparam int TILE_W = N * N * DATA_W;
   localparam int WORD_W = N * DATA_W;
   localparam int KW     = $clog2(2 * N - 1);

   localparam logic [KW-1:0] LAST_K = KW'(2 * N - 2);
   localparam logic [KW-1:0] K_ZERO = KW'(0);
   localparam logic [KW-1:0] K_ONE  = KW'(1);

   typedef enum logic [0:0] {
      ST_IDLE   = 1'b0,
      ST_STREAM = 1'b1
   } state_t;

   state_t              state_r;
   logic [1:0]          full_r;
   logic                wr_ptr_r;
   logic                rd_ptr_r;
   logic [KW-1:0]       k_r;
   logic [TILE_W-1:0]   tile_buf_r [0:1];
   logic [WORD_W-1:0]   out_datain_r;
   logic                out_valid_r;
   logic                out_first_r;
   logic                out_last_r;
   logic                busy_r;

   logic                accept_s;
   logic                emit_s;
   logic                done_s;
   logic [1:0]          full_set_s;
   logic [1:0]          full_clr_s;
   logic [1:0]          full_next_s;
   logic [WORD_W-1:0]   word_s;

   // Builds skewed word k of a tile: lane j takes row (k-j), column j.
   function automatic logic [WORD_W-1:0] skew_word(
      input logic [TILE_W-1:0] tile,
      input logic [KW-1:0]     k
   );
      logic [WORD_W-1:0] w;
      int                row;
      w = {WORD_W{1'b0}};
      for (int j = 0; j < N; j++) begin
         row = int'(k) - j;
         if ((row >= 0) && (row < N)) begin
            w[j*DATA_W +: DATA_W] = tile[(row*N + j)*DATA_W +: DATA_W];
         end else begin
            w[j*DATA_W +: DATA_W] = {DATA_W{1'b0}};
         end
      end
      return w;
   endfunction

   // Write side is free whenever the buffer it points at is empty; no bypass
   // from a same-cycle completion, so a buffer being read is never overwritten.
   assign in_ready = ~full_r[wr_ptr_r];
   assign accept_s = in_valid & in_ready;

   assign out_datain = out_datain_r;
   assign out_valid  = out_valid_r;
   assign out_first  = out_first_r;
   assign out_last   = out_last_r;
   assign busy       = busy_r;

   // Next-cycle buffer occupancy and the word selected for this cycle.
   always_comb begin
      emit_s      = (state_r == ST_STREAM) | full_r[rd_ptr_r];
      done_s      = (state_r == ST_STREAM) & (k_r == LAST_K);
      full_set_s  = accept_s ? (2'b01 << wr_ptr_r) : 2'b00;
      full_clr_s  = done_s   ? (2'b01 << rd_ptr_r) : 2'b00;
      full_next_s = (full_r | full_set_s) & ~full_clr_s;
      word_s      = skew_word(tile_buf_r[rd_ptr_r], k_r);
   end

   // Buffer writes, pointer/step bookkeeping, streaming FSM and output registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r       <= ST_IDLE;
         full_r        <= 2'b00;
         wr_ptr_r      <= 1'b0;
         rd_ptr_r      <= 1'b0;
         k_r           <= K_ZERO;
         tile_buf_r[0] <= {TILE_W{1'b0}};
         tile_buf_r[1] <= {TILE_W{1'b0}};
         out_datain_r  <= {WORD_W{1'b0}};
         out_valid_r   <= 1'b0;
         out_first_r   <= 1'b0;
         out_last_r    <= 1'b0;
         busy_r        <= 1'b0;
      end else begin
         full_r <= full_next_s;
         busy_r <= (|full_next_s) | emit_s;

         if (accept_s) begin
            tile_buf_r[wr_ptr_r] <= in_tile;
            wr_ptr_r             <= ~wr_ptr_r;
         end else begin
            wr_ptr_r <= wr_ptr_r;
         end

         case (state_r)
            ST_IDLE: begin
               if (full_r[rd_ptr_r]) begin
                  // First word goes out on the same edge we leave IDLE.
                  state_r      <= ST_STREAM;
                  out_datain_r <= word_s;
                  out_valid_r  <= 1'b1;
                  out_first_r  <= 1'b1;
                  out_last_r   <= (K_ZERO == LAST_K);
                  k_r          <= K_ONE;
               end else begin
                  state_r      <= ST_IDLE;
                  out_datain_r <= {WORD_W{1'b0}};
                  out_valid_r  <= 1'b0;
                  out_first_r  <= 1'b0;
                  out_last_r   <= 1'b0;
                  k_r          <= K_ZERO;
               end
            end
            ST_STREAM: begin
               out_datain_r <= word_s;
               out_valid_r  <= 1'b1;
               out_first_r  <= (k_r == K_ZERO);
               out_last_r   <= (k_r == LAST_K);
               if (done_s) begin
                  // Continue straight into the other buffer if it is already loaded.
                  k_r      <= K_ZERO;
                  rd_ptr_r <= ~rd_ptr_r;
                  if (full_r[~rd_ptr_r]) begin
                     state_r <= ST_STREAM;
                  end else begin
                     state_r <= ST_IDLE;
                  end
               end else begin
                  k_r <= k_r + K_ONE;
               end
            end
            default: begin
               state_r      <= ST_IDLE;
               out_datain_r <= {WORD_W{1'b0}};
               out_valid_r  <= 1'b0;
               out_first_r  <= 1'b0;
               out_last_r   <= 1'b0;
               k_r          <= K_ZERO;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_systolic_input_skewer.sv
// Directed testbench for systolic_input_skewer (N=4, DATA_W=8).
module tb_systolic_input_skewer;

   logic         clk;
   logic         reset;
   logic         in_valid;
   logic         in_ready;
   logic [127:0] in_tile;
   logic [31:0]  out_datain;
   logic         out_valid;
   logic         out_first;
   logic         out_last;
   logic         busy;

   int checks;
   int failures;

   logic [127:0] tile_a;
   logic [127:0] tile_b;
   logic [127:0] tile_c;
   logic [31:0]  exp_a [7];
   logic [31:0]  exp_b [7];
   logic [31:0]  exp_c [7];

   systolic_input_skewer #(.N(4), .DATA_W(8)) dut (
      .clk        (clk),
      .reset      (reset),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_tile    (in_tile),
      .out_datain (out_datain),
      .out_valid  (out_valid),
      .out_first  (out_first),
      .out_last   (out_last),
      .busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [127:0] make_tile(input logic [7:0] base);
      logic [127:0] t;
      t = 128'd0;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            t[(r*4+c)*8 +: 8] = base + 8'(r*4 + c + 1);
      return t;
   endfunction

   task automatic test_reset();
      reset    = 1'b0;
      in_valid = 1'b0;
      in_tile  = 128'd0;
      #2;
      checks++; if (out_datain !== 32'd0) begin failures++; $display("FAIL reset_datain got=%h exp=%h", out_datain, 32'd0); end
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
      checks++; if (out_first !== 1'b0 || out_last !== 1'b0) begin failures++; $display("FAIL reset_first_last got=%b%b exp=00", out_first, out_last); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
      #20;
      reset = 1'b1;
      tick();
      checks++; if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL post_reset_idle got v=%b b=%b r=%b exp v=0 b=0 r=1", out_valid, busy, in_ready); end
   endtask

   task automatic test_single();
      logic ef, el;
      in_tile  = tile_a;
      in_valid = 1'b1;
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL single_ready got=%b exp=1", in_ready); end
      tick();
      in_valid = 1'b0;
      checks++; if (out_valid !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL single_latency got v=%b b=%b exp v=0 b=1", out_valid, busy); end
      tick();
      for (int k = 0; k < 7; k++) begin
         ef = (k == 0);
         el = (k == 6);
         checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL single_valid k=%0d got=%b exp=1", k, out_valid); end
         checks++; if (out_datain !== exp_a[k]) begin failures++; $display("FAIL single_data k=%0d got=%h exp=%h", k, out_datain, exp_a[k]); end
         checks++; if (out_first !== ef || out_last !== el) begin failures++; $display("FAIL single_flags k=%0d got=%b%b exp=%b%b", k, out_first, out_last, ef, el); end
         tick();
      end
      checks++; if (out_valid !== 1'b0 || out_datain !== 32'd0) begin failures++; $display("FAIL single_end got v=%b d=%h exp v=0 d=0", out_valid, out_datain); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL single_busy_end got=%b exp=0", busy); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] ed;
      logic ef, el;
      in_tile  = tile_a;
      in_valid = 1'b1;
      tick();
      in_tile = tile_b;
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready2 got=%b exp=1", in_ready); end
      tick();
      in_valid = 1'b0;
      for (int i = 0; i < 14; i++) begin
         ed = (i < 7) ? exp_a[i] : exp_b[i-7];
         ef = (i == 0) || (i == 7);
         el = (i == 6) || (i == 13);
         checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL b2b_valid i=%0d got=%b exp=1", i, out_valid); end
         checks++; if (out_datain !== ed) begin failures++; $display("FAIL b2b_data i=%0d got=%h exp=%h", i, out_datain, ed); end
         checks++; if (out_first !== ef || out_last !== el) begin failures++; $display("FAIL b2b_flags i=%0d got=%b%b exp=%b%b", i, out_first, out_last, ef, el); end
         tick();
      end
      checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL b2b_end got v=%b b=%b exp 0 0", out_valid, busy); end
   endtask

   task automatic test_hold_valid();
      logic [31:0] ed;
      logic ef, el, er;
      in_tile  = tile_a;
      in_valid = 1'b1;
      tick();
      in_tile = tile_b;
      tick();
      in_tile = tile_c;
      for (int i = 0; i < 21; i++) begin
         if (i == 7) in_valid = 1'b0;
         ed = (i < 7) ? exp_a[i] : ((i < 14) ? exp_b[i-7] : exp_c[i-14]);
         ef = ((i % 7) == 0);
         el = ((i % 7) == 6);
         er = (i == 6) || (i >= 13);
         checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL hold_valid i=%0d got=%b exp=1", i, out_valid); end
         checks++; if (out_datain !== ed) begin failures++; $display("FAIL hold_data i=%0d got=%h exp=%h", i, out_datain, ed); end
         checks++; if (out_first !== ef || out_last !== el) begin failures++; $display("FAIL hold_flags i=%0d got=%b%b exp=%b%b", i, out_first, out_last, ef, el); end
         checks++; if (in_ready !== er) begin failures++; $display("FAIL hold_in_ready i=%0d got=%b exp=%b", i, in_ready, er); end
         tick();
      end
      checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL hold_end got v=%b b=%b exp 0 0", out_valid, busy); end
   endtask

   task automatic test_reset_mid();
      in_tile  = tile_a;
      in_valid = 1'b1;
      tick();
      in_tile = tile_b;
      tick();
      in_valid = 1'b0;
      tick();
      tick();
      tick();
      checks++; if (out_datain !== exp_a[3]) begin failures++; $display("FAIL rstmid_word4 got=%h exp=%h", out_datain, exp_a[3]); end
      #2;
      reset = 1'b0;
      #1;
      checks++; if (out_valid !== 1'b0 || out_datain !== 32'd0 || out_first !== 1'b0 || out_last !== 1'b0) begin failures++; $display("FAIL rstmid_async got v=%b d=%h f=%b l=%b exp all 0", out_valid, out_datain, out_first, out_last); end
      checks++; if (busy !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL rstmid_async_flags got b=%b r=%b exp b=0 r=1", busy, in_ready); end
      #2;
      reset = 1'b1;
      for (int i = 0; i < 20; i++) begin
         tick();
         checks++; if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL rstmid_after i=%0d got v=%b b=%b r=%b exp v=0 b=0 r=1", i, out_valid, busy, in_ready); end
      end
   endtask

   task automatic test_idle_gap();
      logic ev;
      in_tile  = tile_b;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      for (int c = 0; c < 20; c++) begin
         ev = (c >= 1) && (c <= 7);
         checks++; if (out_valid !== ev) begin failures++; $display("FAIL gap_valid c=%0d got=%b exp=%b", c, out_valid, ev); end
         if (ev) begin
            checks++; if (out_datain !== exp_b[c-1]) begin failures++; $display("FAIL gap_data c=%0d got=%h exp=%h", c, out_datain, exp_b[c-1]); end
         end
         if (c == 19) begin
            in_tile  = tile_c;
            in_valid = 1'b1;
         end
         tick();
      end
      in_valid = 1'b0;
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL gap_accept_edge got=%b exp=0", out_valid); end
      tick();
      for (int k = 0; k < 7; k++) begin
         checks++; if (out_valid !== 1'b1 || out_datain !== exp_c[k]) begin failures++; $display("FAIL gap_tile2 k=%0d got v=%b d=%h exp v=1 d=%h", k, out_valid, out_datain, exp_c[k]); end
         if (k == 0) begin
            checks++; if (out_first !== 1'b1) begin failures++; $display("FAIL gap_first got=%b exp=1", out_first); end
         end
         tick();
      end
      checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL gap_end got v=%b b=%b exp 0 0", out_valid, busy); end
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      tile_a = make_tile(8'h00);
      tile_b = make_tile(8'h20);
      tile_c = make_tile(8'h40);
      exp_a[0] = 32'h0000_0001; exp_a[1] = 32'h0000_0205; exp_a[2] = 32'h0003_0609;
      exp_a[3] = 32'h0407_0A0D; exp_a[4] = 32'h080B_0E00; exp_a[5] = 32'h0C0F_0000;
      exp_a[6] = 32'h1000_0000;
      exp_b[0] = 32'h0000_0021; exp_b[1] = 32'h0000_2225; exp_b[2] = 32'h0023_2629;
      exp_b[3] = 32'h2427_2A2D; exp_b[4] = 32'h282B_2E00; exp_b[5] = 32'h2C2F_0000;
      exp_b[6] = 32'h3000_0000;
      exp_c[0] = 32'h0000_0041; exp_c[1] = 32'h0000_4245; exp_c[2] = 32'h0043_4649;
      exp_c[3] = 32'h4447_4A4D; exp_c[4] = 32'h484B_4E00; exp_c[5] = 32'h4C4F_0000;
      exp_c[6] = 32'h5000_0000;

      test_reset();
      test_single();
      test_back_to_back();
      test_hold_valid();
      test_reset_mid();
      test_idle_gap();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/systolic_input_skewer.md
# systolic_input_skewer

Upstream feeder for the 4x4 `systolic_array`. It accepts whole activation tiles over a valid/ready handshake into a two-entry ping-pong buffer. It replays each tile as 2N-1 diagonally skewed words on the array's `datain` lane bundle, so row r of the tile reaches array row lane j delayed by j cycles. Back-to-back tiles stream with no idle cycle between them.

## Interface
- `N`, default 4: array dimension (lanes, tile rows/cols).
- `DATA_W`, default 8: element width.

- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  tile offered.
- `in_ready`  out  1  write buffer free; transfer on `in_valid && in_ready` at rising edge.
- `in_tile`  in  N*N*DATA_W  row-major tile; element (r,c) at bits [(r*N+c)*DATA_W +: DATA_W].
- `out_datain`  out  N*DATA_W  skewed word to array `datain`; lane j at bits [j*DATA_W +: DATA_W].
- `out_valid`  out  1  `out_datain` carries a tile word.
- `out_first`  out  1  first word (k=0) of a tile.
- `out_last`  out  1  last word (k=2N-2) of a tile.
- `busy`  out  1  either buffer full or streaming in progress.

## Operation
- Storage is two tile buffers (0, 1), each with a `full` flag. It also holds `wr_ptr`, `rd_ptr` and a step counter k of width clog2(2N-1).
- Write side:
  - `in_ready = !full[wr_ptr]`, decoded from registers only.
  - On accept, the tile goes into `buf[wr_ptr]`, `full[wr_ptr]` is set and `wr_ptr` toggles.
- FSM has two states, IDLE and STREAM.
  - IDLE -> STREAM when `full[rd_ptr]` is set. k is 0.
  - In STREAM, each cycle registers word k, then k increments.
  - At k=2N-2 the block clears `full[rd_ptr]`, toggles `rd_ptr` and resets k to 0.
  - After that wrap it stays in STREAM if the other buffer is already full (no gap). Otherwise it returns to IDLE.
- Skew rule for word k, lane j: `a[k-j][j]` when 0 <= k-j <= N-1, else 0.
- `out_first` is high when k==0 and `out_last` is high when k==2N-2; both are only asserted together with `out_valid`.
- When `out_valid` is 0, `out_datain` is all zeros. The array then sees zeros and its accumulators are unaffected.
- `busy = full[0] | full[1] | out_valid`.
- No arithmetic is performed on data; elements pass through bit-exact.

## Timing
- Reset (asynchronous, `reset`=0) clears `full`, both pointers, k, state and all output registers.
  - Reset values: `out_datain`=0, `out_valid`=0, `out_first`=0, `out_last`=0, `busy`=0, `in_ready`=1.
  - Reset mid-stream discards both buffers immediately. No partial tile is emitted after release.
- All outputs except `in_ready` are registered.
- Latency in IDLE: a tile accepted at edge T gives its first word (`out_first`=1) valid after edge T+1. The last word is valid after edge T+2N-1.
- Throughput: one tile per 2N-1 cycles, sustained.
- Buffer freeing: the clear of `full` at the k=2N-2 edge is visible on `in_ready` only from the next cycle.
  - There is no same-cycle bypass.
  - An accept never overwrites a buffer that is being read.
- Simultaneous accept and tile completion on the same edge is legal. Different buffers are involved, and both updates take effect.
- When both buffers are full, `in_ready`=0. `in_tile` is ignored until the streaming tile's last word is registered.
- `in_valid` may drop or rise at any time. Only the sampled handshake matters.

## Test plan
- Single tile, a[r][c]=r*4+c+1 (0x01..0x10). Required response is 7 consecutive valid words:
  - 0x0000_0001, 0x0000_0205, 0x0003_0609, 0x0407_0A0D, 0x080B_0E00, 0x0C0F_0000, 0x1000_0000.
  - `out_first` on word 1, `out_last` on word 7.
  - Then `out_valid`=0, `out_datain`=0, `busy`=0.
- Two tiles accepted on consecutive edges:
  - 14 contiguous valid cycles.
  - `out_first` on cycles 1 and 8, `out_last` on cycles 7 and 14.
  - Second tile is bit-exact with its own skew.
- `in_valid` held high with three distinct tiles:
  - First two accepted on consecutive edges; `in_ready` low until after the first tile's `out_last` cycle.
  - Third accepted then and emitted immediately after tile 2, with no gap.
- Assert `reset`=0 during word 4 of a tile with a second tile buffered:
  - All outputs go to 0 asynchronously, before the next edge.
  - After release, `in_ready`=1 and `busy`=0; no words from either tile appear.
- Idle gap: accept a tile, wait 20 cycles, accept another.
  - `out_valid` stays 0 throughout the gap.
  - Second tile's first word is valid exactly 1 cycle after its accept edge.
